// File: rtl/shift_tx_sched.sv
`default_nettype none
// ============================================================================
// shift_tx_sched : round-robin two-requester scheduler feeding an MSB-first
//                  serializer with frame strobe and post-frame idle gap.
// Revision 1.0
// ============================================================================
module shift_tx_sched #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sdo,
  output logic             sframe,
  output logic             grant_id,
  output logic             busy,
  output logic             done
);

  localparam int c_cnt_w = $clog2(WIDTH);
  localparam int c_gap_w = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WIDTH - 1);
  localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [c_cnt_w-1:0] r_bit_cnt;
  logic [c_gap_w-1:0] r_gap_cnt;
  logic               r_prio;
  logic               r_sframe;
  logic               r_grant;
  logic               r_busy;
  logic               r_done;

  logic w_idle;
  logic w_pick1;
  logic w_take;

  // Readys are held low while reset is asserted so no word is taken then.
  assign w_idle     = (r_state == S_IDLE) && reset_n;
  assign w_pick1    = req1_valid && (!req0_valid || r_prio);
  assign req1_ready = w_idle && w_pick1;
  assign req0_ready = w_idle && req0_valid && !w_pick1;
  assign w_take     = req0_ready || req1_ready;

  // The shifter refills with zeros, so its MSB is already 0 outside a frame.
  assign sdo      = r_shreg[WIDTH-1];
  assign sframe   = r_sframe;
  assign grant_id = r_grant;
  assign busy     = r_busy;
  assign done     = r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_prio    <= 1'b0;
      r_sframe  <= 1'b0;
      r_grant   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_shreg   <= w_pick1 ? req1_data : req0_data;
            r_grant   <= w_pick1;
            r_prio    <= !w_pick1;
            r_bit_cnt <= c_cnt_load;
            r_sframe  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
          if (r_bit_cnt != '0) begin
            r_bit_cnt <= r_bit_cnt - c_cnt_w'(1);
          end else begin
            r_sframe <= 1'b0;
            r_done   <= 1'b1;
            if (GAP > 0) begin
              r_gap_cnt <= c_gap_load;
              r_state   <= S_GAP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - c_gap_w'(1);
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_tx_sched.sv
`default_nettype none
// ============================================================================
// tb_shift_tx_sched : cycle model with bit scoreboard, vector table, corner cases
// Revision 1.0
// ============================================================================
module tb_shift_tx_sched;

  localparam int W = 8;
  localparam int G = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready, sdo, sframe, grant_id, busy, done;

  logic         z0_valid, z1_valid;
  logic [W-1:0] z0_data, z1_data;
  logic         z0_ready, z1_ready, z_sdo, z_sframe, z_grant, z_busy, z_done;

  shift_tx_sched #(.WIDTH(W), .GAP(G)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .sdo(sdo), .sframe(sframe), .grant_id(grant_id), .busy(busy), .done(done)
  );

  shift_tx_sched #(.WIDTH(W), .GAP(0)) dut_nogap (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(z0_valid), .req0_data(z0_data), .req0_ready(z0_ready),
    .req1_valid(z1_valid), .req1_data(z1_data), .req1_ready(z1_ready),
    .sdo(z_sdo), .sframe(z_sframe), .grant_id(z_grant), .busy(z_busy), .done(z_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    int   cyc;
    logic id;
  } hs_t;
  hs_t hs_log[$];

  // Reference model of the GAP=G instance; sb holds the bits still owed on sdo.
  logic sb[$];
  int   m_st = 0;
  int   m_bits = 0;
  int   m_gap = 0;
  logic m_prio = 1'b0;
  logic m_grant = 1'b0;
  logic m_done = 1'b0;

  initial begin : model
    logic         e_r0, e_r1, e_sdo;
    logic [6:0]   exp_v, act_v;
    logic [W-1:0] d;
    forever begin
      @(negedge clk);
      cyc++;
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      e_sdo = 1'b0;
      if (!reset_n) begin
        m_st = 0; m_bits = 0; m_gap = 0;
        m_prio = 1'b0; m_grant = 1'b0; m_done = 1'b0;
        sb.delete();
        exp_v = '0;
      end else begin
        e_r1 = (m_st == 0) && req1_valid && (!req0_valid || m_prio);
        e_r0 = (m_st == 0) && req0_valid && !e_r1;
        if (m_st == 1 && sb.size() > 0) e_sdo = sb.pop_front();
        exp_v = {e_r0, e_r1, e_sdo, m_st == 1, m_st != 0, m_done, m_grant};
      end
      act_v = {req0_ready, req1_ready, sdo, sframe, busy, done, grant_id};
      check("outputs", act_v, exp_v);
      if (reset_n && req0_valid && req0_ready) hs_log.push_back('{cyc, 1'b0});
      if (reset_n && req1_valid && req1_ready) hs_log.push_back('{cyc, 1'b1});
      if (reset_n) begin
        m_done = 1'b0;
        case (m_st)
          0: if (e_r0 || e_r1) begin
            d = e_r1 ? req1_data : req0_data;
            for (int b = W - 1; b >= 0; b--) sb.push_back(d[b]);
            m_grant = e_r1;
            m_prio  = !e_r1;
            m_bits  = W;
            m_st    = 1;
          end
          1: begin
            m_bits--;
            if (m_bits == 0) begin
              m_done = 1'b1;
              if (G > 0) begin m_st = 2; m_gap = G; end
              else m_st = 0;
            end
          end
          default: begin
            m_gap--;
            if (m_gap == 0) m_st = 0;
          end
        endcase
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    z0_valid = 1'b0;   z1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    logic         v0;
    logic [W-1:0] d0;
    logic         v1;
    logic [W-1:0] d1;
    int           hold;
    int           exp_hs;
    logic         exp_first;
  } vec_t;
  vec_t tbl[5];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    logic         exp_id;
    logic [W-1:0] pat;
    logic [W-1:0] got;
    logic [W-1:0] dat;
    int           rdy;
    int           ph, j;
    logic [5:0]   zexp, zact;

    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    z0_valid = 1'b0;   z1_valid = 1'b0;   z0_data = '0;   z1_data = '0;

    tbl[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 12, 2, 1'b0};
    tbl[1] = '{1'b1, 8'h0F, 1'b1, 8'hF0, 40, 4, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 8'h81, 30, 3, 1'b1};
    tbl[3] = '{1'b0, 8'h77, 1'b0, 8'h66, 15, 0, 1'b0};
    tbl[4] = '{1'b1, 8'h3C, 1'b1, 8'hC3,  5, 1, 1'b0};

    // Reset state
    @(negedge clk);
    check("reset_outputs", {req0_ready, req1_ready, sdo, sframe, busy, done, grant_id}, 7'd0);

    for (int i = 0; i < 5; i++) begin
      apply_reset();
      req0_valid = tbl[i].v0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_data = tbl[i].d1;
      start = cyc + 1;
      hs_log.delete();
      repeat (tbl[i].hold) @(posedge clk);
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (W + G + 4) @(posedge clk);
      check($sformatf("vec%0d_hs_count", i), hs_log.size(), tbl[i].exp_hs);
      foreach (hs_log[k]) begin
        check($sformatf("vec%0d_hs%0d_cycle", i, k), hs_log[k].cyc - start, k * (W + G + 1));
        exp_id = tbl[i].exp_first ^ ((tbl[i].v0 && tbl[i].v1) && (k % 2 == 1));
        check($sformatf("vec%0d_hs%0d_id", i, k), hs_log[k].id, exp_id);
      end
    end

    // Single A5 frame: bit order, done timing, gap release
    apply_reset();
    req0_valid = 1'b1; req0_data = 8'hA5;
    pat = 8'hA5;
    @(negedge clk);
    check("a5_ready", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check($sformatf("a5_bit%0d", i), {sdo, sframe, grant_id}, {pat[W-1-i], 1'b1, 1'b0});
    end
    @(negedge clk);
    check("a5_done", {done, busy, sframe, sdo}, 4'b1100);
    @(negedge clk);
    check("a5_idle", {done, busy}, 2'b00);
    repeat (3) @(posedge clk);

    // Data edits while waiting are ignored; only the handshake value is sent
    apply_reset();
    req1_valid = 1'b1; req1_data = 8'h5A;
    @(negedge clk);
    check("edit_r1_ready", {req0_ready, req1_ready}, 2'b01);
    @(posedge clk);
    #1;
    req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 8'h00;
    rdy = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      rdy += int'(req0_ready | req1_ready);
      @(posedge clk);
      #1;
      if (k == 3) req0_data = 8'hFF;
    end
    check("edit_no_ready_midframe", rdy, 0);
    @(negedge clk);
    check("edit_r0_ready", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    got = '0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      got = {got[W-2:0], sdo};
    end
    check("edit_frame_data", got, 8'hFF);
    repeat (4) @(posedge clk);

    // Reset mid-frame aborts and restores req0 priority
    apply_reset();
    req0_valid = 1'b1; req0_data = 8'h0F;
    req1_valid = 1'b1; req1_data = 8'hF0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("abort_outputs", {sdo, sframe, busy, done, req0_ready, req1_ready}, 6'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("abort_tie_req0", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (W + G + 4) @(posedge clk);

    // GAP=0 instance: back-to-back alternating frames
    apply_reset();
    z0_valid = 1'b1; z0_data = 8'h0F;
    z1_valid = 1'b1; z1_data = 8'hF0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      ph  = k % (W + 1);
      j   = k / (W + 1);
      dat = (j % 2 == 0) ? 8'h0F : 8'hF0;
      zexp[5] = (ph == 0) && (j % 2 == 0);
      zexp[4] = (ph == 0) && (j % 2 == 1);
      zexp[3] = (ph != 0) ? dat[W-ph] : 1'b0;
      zexp[2] = (ph != 0);
      zexp[1] = (ph == 0) && (k > 0);
      zexp[0] = (k == 0) ? 1'b0 : (((k - 1) / (W + 1)) % 2 == 1);
      zact = {z0_ready, z1_ready, z_sdo, z_sframe, z_done, z_grant};
      check($sformatf("nogap_c%0d", k), zact, zexp);
      check($sformatf("nogap_busy%0d", k), z_busy, zexp[2]);
    end
    @(posedge clk);
    #1;
    z0_valid = 1'b0; z1_valid = 1'b0;
    repeat (W + 3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
